// File: rtl/cam_tg_pkg.sv
// rtl/cam_tg_pkg.sv - shared types and constants for the test-pattern camera source
package cam_tg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } tg_state_t;

  localparam logic [1:0] PAT_RAMP = 2'd0;
  localparam logic [1:0] PAT_BARS = 2'd1;
  localparam logic [1:0] PAT_FLAT = 2'd2;
  localparam logic [1:0] PAT_ZERO = 2'd3;

  // Bar colors as {R,G,B}; index 0 is the leftmost bar (white) through 7 (black)
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000,  // black
    3'b001,  // blue
    3'b100,  // red
    3'b101,  // magenta
    3'b010,  // green
    3'b011,  // cyan
    3'b110,  // yellow
    3'b111   // white
  };

endpackage

// File: rtl/bayer_bar_lut.sv
// rtl/bayer_bar_lut.sv - picks the RGGB channel of a color bar for one pixel site
module bayer_bar_lut #(
  parameter int PIX_W = 8
) (
  input  logic [2:0]       bar_idx,
  input  logic             x_lsb,
  input  logic             y_lsb,
  output logic [PIX_W-1:0] value
);
  import cam_tg_pkg::*;

  logic [2:0] rgb;
  logic       chan_on;

  always_comb begin
    rgb     = BAR_RGB[bar_idx];
    chan_on = 1'b0;
    case ({y_lsb, x_lsb})
      2'b00:   chan_on = rgb[2];
      2'b11:   chan_on = rgb[0];
      default: chan_on = rgb[1];
    endcase
    value = {PIX_W{chan_on}};
  end

endmodule

// File: rtl/cam_timing_gen.sv
// rtl/cam_timing_gen.sv - DVP-style frame timing and test-pattern pixel source
module cam_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 160,
  parameter int V_ACTIVE  = 480,
  parameter int VSYNC_LEN = 4,
  parameter int V_BACK    = 8,
  parameter int V_FRONT   = 8,
  parameter int PIX_W     = 8,
  parameter int BAR_SHIFT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       pattern_sel,
  output logic             cam_vsync,
  output logic             cam_href,
  output logic [PIX_W-1:0] cam_data,
  output logic             frame_start,
  output logic             busy
);
  import cam_tg_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_MAX_A = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int V_MAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int V_W     = $clog2(V_MAX + 1);

  tg_state_t        state_q, state_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [V_W-1:0]   v_q, v_d;
  logic [V_W-1:0]   last_line;
  logic [1:0]       pat_q;
  logic [PIX_W-1:0] frame_cnt_q;

  logic             frame_entry;
  logic             href_d;
  logic [2:0]       bar_idx;
  logic [PIX_W-1:0] bar_value;
  logic [PIX_W-1:0] pix_d;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    last_line = '0;
    case (state_q)
      VSYNC:   last_line = V_W'(VSYNC_LEN - 1);
      VBACK:   last_line = V_W'(V_BACK - 1);
      ACTIVE:  last_line = V_W'(V_ACTIVE - 1);
      VFRONT:  last_line = V_W'(V_FRONT - 1);
      default: last_line = '0;
    endcase

    if (state_q == IDLE) begin
      h_d = '0;
      v_d = '0;
      if (en) state_d = VSYNC;
    end else if (h_q == H_W'(H_TOTAL - 1)) begin
      h_d = '0;
      if (v_q == last_line) begin
        v_d = '0;
        case (state_q)
          VSYNC:   state_d = VBACK;
          VBACK:   state_d = ACTIVE;
          ACTIVE:  state_d = VFRONT;
          VFRONT:  state_d = en ? VSYNC : IDLE;
          default: state_d = IDLE;
        endcase
      end else begin
        v_d = v_q + 1'b1;
      end
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // Outputs are built from the next state/counters so they line up with the state register
  assign frame_entry = (state_d == VSYNC) && (state_q != VSYNC);
  assign href_d      = (state_d == ACTIVE) && (h_d < H_W'(H_ACTIVE));
  assign bar_idx     = 3'(h_d >> BAR_SHIFT);

  bayer_bar_lut #(
    .PIX_W(PIX_W)
  ) u_bar_lut (
    .bar_idx(bar_idx),
    .x_lsb  (h_d[0]),
    .y_lsb  (v_d[0]),
    .value  (bar_value)
  );

  always_comb begin
    pix_d = '0;
    if (href_d) begin
      case (pat_q)
        PAT_RAMP: pix_d = PIX_W'(h_d);
        PAT_BARS: pix_d = bar_value;
        PAT_FLAT: pix_d = frame_cnt_q;
        default:  pix_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      h_q         <= '0;
      v_q         <= '0;
      pat_q       <= PAT_RAMP;
      frame_cnt_q <= '0;
      cam_vsync   <= 1'b0;
      cam_href    <= 1'b0;
      cam_data    <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      if (frame_entry) begin
        pat_q       <= pattern_sel;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      cam_vsync   <= (state_d == VSYNC);
      cam_href    <= href_d;
      cam_data    <= pix_d;
      frame_start <= frame_entry;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_cam_timing_gen.sv
// tb/tb_cam_timing_gen.sv - scoreboard bench for cam_timing_gen on a 12x7-line toy frame
module tb_cam_timing_gen;

  localparam int HA = 8;
  localparam int HB = 4;
  localparam int VA = 4;
  localparam int VS = 1;
  localparam int VBK = 1;
  localparam int VF = 1;
  localparam int PW = 8;
  localparam int BS = 2;
  localparam int HT = HA + HB;
  localparam int FRAME = HT * (VS + VBK + VA + VF);

  localparam int K_RAMP = 0;
  localparam int K_BARS = 1;
  localparam int K_FLAT = 2;
  localparam int K_ZERO = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    pattern_sel;
  logic          cam_vsync;
  logic          cam_href;
  logic [PW-1:0] cam_data;
  logic          frame_start;
  logic          busy;

  always #5 clk = ~clk;

  cam_timing_gen #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .VSYNC_LEN(VS),
    .V_BACK   (VBK),
    .V_FRONT  (VF),
    .PIX_W    (PW),
    .BAR_SHIFT(BS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pattern_sel(pattern_sel),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .frame_start(frame_start),
    .busy       (busy)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t pix_q[$];
  int   vs_q[$];
  int   cyc = 0;
  int   base = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  logic vs_prev = 1'b0;
  exp_t mon_e;
  int   mon_r;

  // Odd lines of the white/yellow bar pair: G,B,G,B sites
  logic [7:0] bar_odd [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc - base);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (cam_href) begin
        if (pix_q.size() == 0) begin
          check("unexpected_href", 1, 0);
        end else begin
          mon_e = pix_q.pop_front();
          check("href_cycle", cyc - base, mon_e.cyc - base);
          check("pixel", int'(cam_data), int'(mon_e.data));
        end
      end else begin
        check("blank_data", int'(cam_data), 0);
      end
      if (cam_href && cam_vsync) check("href_vsync_overlap", 1, 0);
      if (cam_vsync && !vs_prev) begin
        if (vs_q.size() == 0) begin
          check("unexpected_vsync", 1, 0);
        end else begin
          mon_r = vs_q.pop_front();
          check("vsync_rise", cyc - base, mon_r - base);
        end
        check("frame_start_on_rise", int'(frame_start), 1);
      end else begin
        check("frame_start_off", int'(frame_start), 0);
      end
      vs_prev <= cam_vsync;
    end
  end

  task automatic wait_k(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vsync"}, int'(cam_vsync), 0);
    check({tag, "_href"}, int'(cam_href), 0);
    check({tag, "_data"}, int'(cam_data), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic go();
    en   = 1'b1;
    base = cyc;
  endtask

  task automatic push_frame(input int f, input int kind, input int flatv);
    exp_t e;
    vs_q.push_back(base + 1 + FRAME * f);
    for (int l = 0; l < VA; l++) begin
      for (int x = 0; x < HA; x++) begin
        e.cyc = base + 25 + FRAME * f + HT * l + x;
        case (kind)
          K_RAMP:  e.data = 8'(x);
          K_FLAT:  e.data = 8'(flatv);
          K_BARS:  e.data = (l % 2 == 0) ? 8'hFF : bar_odd[x];
          default: e.data = 8'h00;
        endcase
        pix_q.push_back(e);
      end
    end
  endtask

  task automatic finish_scn(input string name);
    check({name, "_pix_left"}, pix_q.size(), 0);
    check({name, "_vsync_left"}, vs_q.size(), 0);
    pix_q.delete();
    vs_q.delete();
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    en = 1'b0;
    pattern_sel = 2'd0;
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    do_reset();

    // Two frames back to back: ramp, then zero latched at the second vsync
    pattern_sel = 2'd0;
    go();
    push_frame(0, K_RAMP, 0);
    push_frame(1, K_ZERO, 0);
    wait_k(1);
    check("s1_busy_rise", int'(busy), 1);
    check("s1_vsync_rise", int'(cam_vsync), 1);
    wait_k(12);
    check("s1_vsync_last", int'(cam_vsync), 1);
    wait_k(13);
    check("s1_vsync_fall", int'(cam_vsync), 0);
    wait_k(50);
    pattern_sel = 2'd3;
    wait_k(100);
    en = 1'b0;
    wait_k(2 * FRAME);
    check("s1_busy_last", int'(busy), 1);
    wait_k(2 * FRAME + 1);
    check("s1_busy_fall", int'(busy), 0);
    wait_k(200);
    finish_scn("s1");

    // en dropped and pattern changed mid-frame: frame completes as ramp, then idle
    do_reset();
    pattern_sel = 2'd0;
    go();
    push_frame(0, K_RAMP, 0);
    wait_k(30);
    pattern_sel = 2'd1;
    wait_k(40);
    en = 1'b0;
    wait_k(FRAME);
    check("s2_busy_last", int'(busy), 1);
    wait_k(FRAME + 1);
    check("s2_busy_fall", int'(busy), 0);
    wait_k(200);
    check("s2_idle_busy", int'(busy), 0);
    finish_scn("s2");

    // Bayer bars, BAR_SHIFT=2: white then yellow
    do_reset();
    pattern_sel = 2'd1;
    go();
    push_frame(0, K_BARS, 0);
    wait_k(2);
    en = 1'b0;
    wait_k(100);
    finish_scn("s3");

    // Flat frame count through the 8-bit wrap
    do_reset();
    pattern_sel = 2'd2;
    go();
    for (int f = 0; f < 257; f++) push_frame(f, K_FLAT, (f + 1) % 256);
    wait_k(FRAME * 256 + 40);
    en = 1'b0;
    wait_k(FRAME * 257 + 10);
    finish_scn("s4");

    // Reset mid-href, then a clean restart with frame_cnt back to 0
    do_reset();
    pattern_sel = 2'd2;
    go();
    vs_q.push_back(base + 1);
    for (int x = 0; x < 6; x++) begin
      e.cyc  = base + 25 + x;
      e.data = 8'd1;
      pix_q.push_back(e);
    end
    wait_k(30);
    rst = 1'b1;
    en  = 1'b0;
    wait_k(31);
    check_all_zero("s5_midrst");
    rst = 1'b0;
    finish_scn("s5a");
    wait_k(33);
    go();
    push_frame(0, K_FLAT, 1);
    wait_k(1);
    check("s5_restart_busy", int'(busy), 1);
    wait_k(2);
    en = 1'b0;
    wait_k(FRAME + 1);
    check("s5_busy_fall", int'(busy), 0);
    wait_k(120);
    finish_scn("s5b");

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
